// File: rtl/isa_pkg.sv
// Shared ISA view for the hazard unit: opcode constants, field slices and
// read/write-set decode helpers for the 5-stage pipeline.
package isa_pkg;

    localparam logic [4:0] OP_ALU  = 5'd0;
    localparam logic [4:0] OP_J    = 5'd1;
    localparam logic [4:0] OP_BNE  = 5'd2;
    localparam logic [4:0] OP_JAL  = 5'd3;
    localparam logic [4:0] OP_JR   = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_BLT  = 5'd6;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] OP_SETX = 5'd21;
    localparam logic [4:0] OP_BEX  = 5'd22;

    localparam logic [4:0] ALUOP_MUL = 5'd6;
    localparam logic [4:0] ALUOP_DIV = 5'd7;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 22;
    localparam int RS_HI    = 21;
    localparam int RS_LO    = 17;
    localparam int RT_HI    = 16;
    localparam int RT_LO    = 12;
    localparam int ALUOP_HI = 6;
    localparam int ALUOP_LO = 2;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam logic [4:0] REG_RSTATUS = 5'd30;
    localparam logic [4:0] REG_RA      = 5'd31;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_MW = 2'b01;
    localparam logic [1:0] FWD_XM = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic [4:0] f_op(input logic [31:0] ir);
        return ir[OP_HI:OP_LO];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[RD_HI:RD_LO];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[RT_HI:RT_LO];
    endfunction

    // Destination register, or r0 when the instruction writes nothing.
    function automatic logic [4:0] dest_reg(input logic [31:0] ir);
        case (f_op(ir))
            OP_ALU, OP_ADDI, OP_LW: return f_rd(ir);
            OP_JAL:                 return REG_RA;
            OP_SETX:                return REG_RSTATUS;
            default:                return REG_ZERO;
        endcase
    endfunction

    function automatic logic [4:0] src_a(input logic [31:0] ir);
        case (f_op(ir))
            OP_ALU, OP_ADDI, OP_SW, OP_LW: return f_rs(ir);
            OP_BNE, OP_JR, OP_BLT:         return f_rd(ir);
            default:                       return REG_ZERO;
        endcase
    endfunction

    function automatic logic [4:0] src_b(input logic [31:0] ir);
        case (f_op(ir))
            OP_ALU:         return f_rt(ir);
            OP_SW:          return f_rd(ir);
            OP_BNE, OP_BLT: return f_rs(ir);
            default:        return REG_ZERO;
        endcase
    endfunction

    // bex reads rstatus implicitly, so it is not covered by the A/B operands.
    function automatic logic reads_reg(input logic [31:0] ir, input logic [4:0] r);
        if (r == REG_ZERO) return 1'b0;
        return (src_a(ir) == r) || (src_b(ir) == r) ||
               ((f_op(ir) == OP_BEX) && (r == REG_RSTATUS));
    endfunction

    function automatic logic is_muldiv(input logic [31:0] ir);
        return (f_op(ir) == OP_ALU) &&
               ((ir[ALUOP_HI:ALUOP_LO] == ALUOP_MUL) || (ir[ALUOP_HI:ALUOP_LO] == ALUOP_DIV));
    endfunction

    function automatic logic [1:0] fwd_select(input logic [4:0] src, input logic [4:0] xm_dst,
                                              input logic [4:0] mw_dst);
        if (src == REG_ZERO) return FWD_RF;
        if (src == xm_dst)   return FWD_XM;
        if (src == mw_dst)   return FWD_MW;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Mult/div sequencer: launches the unit, freezes the front of the pipe while it
// runs, and gives up with a sticky error if the unit never answers.
module md_sequencer
    import isa_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic start_req,
    input  logic md_ready,
    output logic md_start,
    output logic md_busy,
    output logic md_error,
    output logic stall_all
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    md_state_t        state;
    md_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic             timeout;

    always_comb begin
        state_nx = state;
        timeout  = 1'b0;
        case (state)
            MD_IDLE: if (start_req) state_nx = MD_RUN;
            MD_RUN: begin
                if (md_ready) begin
                    state_nx = MD_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nx = MD_IDLE;
                    timeout  = 1'b1;
                end
            end
            MD_DONE: state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            md_start <= 1'b0;
            md_error <= 1'b0;
        end else begin
            state    <= state_nx;
            md_start <= (state == MD_IDLE) && start_req;
            if (state == MD_IDLE) begin
                cnt <= '0;
            end else if (state == MD_RUN) begin
                cnt <= cnt + 1'b1;
            end
            if (timeout) md_error <= 1'b1;
        end
    end

    // DONE drops the freeze so the unit's result can latch into XM.
    assign md_busy   = (state == MD_RUN);
    assign stall_all = md_busy;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: RAW stall detection, operand forwarding selects and
// the mult/div front-end freeze.
module hazard_scoreboard
    import isa_pkg::*;
#(
    parameter int FWD_EN     = 1,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic [31:0] xm_ir,
    input  logic [31:0] mw_ir,
    input  logic        md_ready,
    output logic        stall_fd,
    output logic        stall_all,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_error,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        fwd_wm
);

    logic [4:0] dx_dst;
    logic [4:0] xm_dst;
    logic [4:0] mw_dst;
    logic       raw_stall;
    logic       unused_ir_bits;

    assign dx_dst = dest_reg(dx_ir);
    assign xm_dst = dest_reg(xm_ir);
    assign mw_dst = dest_reg(mw_ir);

    // Immediate/shamt bits never matter for hazards.
    assign unused_ir_bits = ^{fd_ir, dx_ir, xm_ir, mw_ir};

    always_comb begin
        fwd_a     = FWD_RF;
        fwd_b     = FWD_RF;
        fwd_wm    = 1'b0;
        raw_stall = 1'b0;
        if (FWD_EN != 0) begin
            fwd_a     = fwd_select(src_a(dx_ir), xm_dst, mw_dst);
            fwd_b     = fwd_select(src_b(dx_ir), xm_dst, mw_dst);
            fwd_wm    = (f_op(xm_ir) == OP_SW) && (mw_dst != REG_ZERO) && (mw_dst == f_rd(xm_ir));
            // Only a load's result is too late to forward into the next X stage.
            raw_stall = (f_op(dx_ir) == OP_LW) && reads_reg(fd_ir, f_rd(dx_ir));
        end else begin
            raw_stall = reads_reg(fd_ir, dx_dst) || reads_reg(fd_ir, xm_dst);
        end
        stall_fd = raw_stall && !stall_all;
    end

    md_sequencer #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_seq (
        .clock     (clock),
        .reset     (reset),
        .start_req (is_muldiv(dx_ir)),
        .md_ready  (md_ready),
        .md_start  (md_start),
        .md_busy   (md_busy),
        .md_error  (md_error),
        .stall_all (stall_all)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two hazard units (forwarding/64-cycle timeout and
// stall-only/8-cycle timeout) driven by directed pipeline snapshots.
module tb_hazard_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_ir = '0;
    logic [31:0] dx_ir = '0;
    logic [31:0] xm_ir = '0;
    logic [31:0] mw_ir = '0;
    logic        md_ready = 1'b0;

    logic       s1_stall_fd, s1_stall_all, s1_md_start, s1_md_busy, s1_md_error, s1_fwd_wm;
    logic [1:0] s1_fwd_a, s1_fwd_b;
    logic       s2_stall_fd, s2_stall_all, s2_md_start, s2_md_busy, s2_md_error, s2_fwd_wm;
    logic [1:0] s2_fwd_a, s2_fwd_b;

    hazard_scoreboard #(.FWD_EN(1), .MD_TIMEOUT(64), .CNT_W(7)) dut (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir), .xm_ir(xm_ir),
        .mw_ir(mw_ir), .md_ready(md_ready), .stall_fd(s1_stall_fd), .stall_all(s1_stall_all),
        .md_start(s1_md_start), .md_busy(s1_md_busy), .md_error(s1_md_error),
        .fwd_a(s1_fwd_a), .fwd_b(s1_fwd_b), .fwd_wm(s1_fwd_wm)
    );

    hazard_scoreboard #(.FWD_EN(0), .MD_TIMEOUT(8), .CNT_W(4)) dut_nf (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir), .xm_ir(xm_ir),
        .mw_ir(mw_ir), .md_ready(md_ready), .stall_fd(s2_stall_fd), .stall_all(s2_stall_all),
        .md_start(s2_md_start), .md_busy(s2_md_busy), .md_error(s2_md_error),
        .fwd_a(s2_fwd_a), .fwd_b(s2_fwd_b), .fwd_wm(s2_fwd_wm)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // {stall_fd, stall_all, md_start, md_busy, md_error, fwd_a, fwd_b, fwd_wm}
    logic [9:0] v1, v2;
    assign v1 = {s1_stall_fd, s1_stall_all, s1_md_start, s1_md_busy, s1_md_error, s1_fwd_a, s1_fwd_b, s1_fwd_wm};
    assign v2 = {s2_stall_fd, s2_stall_all, s2_md_start, s2_md_busy, s2_md_error, s2_fwd_a, s2_fwd_b, s2_fwd_wm};

    typedef struct {
        int         cyc;
        int         which;
        logic [9:0] vec;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    always @(negedge clock) begin : monitor
        exp_t       e;
        logic [9:0] got;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            got = (e.which == 2) ? v2 : v1;
            checks++;
            if (e.cyc != cyc || got !== e.vec) begin
                fails++;
                $display("FAIL %s dut%0d cycle %0d: got %b expected %b (sfd,sall,start,busy,err,fa,fb,wm)",
                         e.name, e.which, cyc, got, e.vec);
            end
        end
    end

    function automatic logic [31:0] ins(input int op, input int rd, input int rs,
                                        input int rt, input int aluop);
        logic [31:0] w;
        w        = '0;
        w[31:27] = 5'(op);
        w[26:22] = 5'(rd);
        w[21:17] = 5'(rs);
        w[16:12] = 5'(rt);
        w[6:2]   = 5'(aluop);
        return w;
    endfunction

    function automatic logic [9:0] ev(input bit sfd, input bit sall, input bit start,
                                      input bit busy, input bit err, input logic [1:0] fa,
                                      input logic [1:0] fb, input bit wm);
        return {sfd, sall, start, busy, err, fa, fb, wm};
    endfunction

    task automatic step(input logic [31:0] f, input logic [31:0] d, input logic [31:0] x,
                        input logic [31:0] m, input logic rdy);
        @(posedge clock);
        #1;
        fd_ir = f; dx_ir = d; xm_ir = x; mw_ir = m; md_ready = rdy;
    endtask

    task automatic expect_out(input int which, input string name, input logic [9:0] v);
        exp_t e;
        e.cyc = cyc; e.which = which; e.vec = v; e.name = name;
        q.push_back(e);
    endtask

    task automatic pulse_reset();
        step('0, '0, '0, '0, 1'b0);
        reset = 1'b1;
        step('0, '0, '0, '0, 1'b0);
        reset = 1'b0;
    endtask

    logic [31:0] nop, mul, div_i, add435;
    logic [9:0]  zero;

    initial begin
        nop    = '0;
        zero   = '0;
        mul    = ins(0, 4, 1, 2, 6);
        div_i  = ins(0, 4, 1, 2, 7);
        add435 = ins(0, 4, 3, 5, 0);

        repeat (2) @(posedge clock);
        step(nop, nop, nop, nop, 1'b0);
        reset = 1'b0;
        expect_out(1, "reset_state", zero);
        expect_out(2, "reset_state", zero);

        // T1 load-use
        step(add435, ins(8, 3, 1, 0, 0), nop, nop, 1'b0);
        expect_out(1, "t1_lw_stall", ev(1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        expect_out(2, "t1_lw_stall", ev(1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        step(add435, nop, ins(8, 3, 1, 0, 0), nop, 1'b0);
        expect_out(1, "t1_bubble", zero);
        expect_out(2, "t1_xm_stall", ev(1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        step(nop, add435, nop, ins(8, 3, 1, 0, 0), 1'b0);
        expect_out(1, "t1_fwd_mw", ev(0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
        expect_out(2, "t1_nofwd", zero);

        // T2 XM priority over MW
        step(nop, ins(0, 6, 3, 3, 1), ins(0, 3, 1, 2, 0), ins(5, 3, 1, 0, 0), 1'b0);
        expect_out(1, "t2_xm_prio", ev(0, 0, 0, 0, 0, 2'b10, 2'b10, 0));
        expect_out(2, "t2_nofwd", zero);
        step(nop, ins(0, 6, 3, 3, 1), nop, ins(5, 3, 1, 0, 0), 1'b0);
        expect_out(1, "t2_mw_only", ev(0, 0, 0, 0, 0, 2'b01, 2'b01, 0));

        // T3 r0 never matches
        step(ins(0, 4, 0, 0, 0), ins(8, 0, 1, 0, 0), nop, nop, 1'b0);
        expect_out(1, "t3_lw_r0", zero);
        expect_out(2, "t3_lw_r0", zero);
        step(nop, ins(0, 5, 0, 0, 0), ins(5, 0, 1, 0, 0), ins(0, 0, 1, 2, 0), 1'b0);
        expect_out(1, "t3_fwd_r0", zero);

        // T4 stall-only mode
        step(ins(2, 7, 2, 0, 0), nop, ins(0, 7, 1, 2, 0), nop, 1'b0);
        expect_out(2, "t4_bne_xm", ev(1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        expect_out(1, "t4_fwd_nostall", zero);

        // operand mapping, store-data forward, implicit r30, jr read
        step(nop, ins(7, 9, 1, 0, 0), ins(5, 9, 1, 0, 0), nop, 1'b0);
        expect_out(1, "sw_b_rd", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 0));
        step(nop, ins(2, 4, 5, 0, 0), nop, ins(0, 5, 1, 2, 0), 1'b0);
        expect_out(1, "bne_b_rs", ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 0));
        step(nop, nop, ins(7, 9, 1, 0, 0), ins(8, 9, 2, 0, 0), 1'b0);
        expect_out(1, "fwd_wm", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        expect_out(2, "fwd_wm_off", zero);
        step(ins(22, 0, 0, 0, 0), ins(21, 0, 0, 0, 0), nop, nop, 1'b0);
        expect_out(2, "bex_setx", ev(1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        expect_out(1, "bex_setx", zero);
        step(ins(4, 7, 0, 0, 0), ins(8, 7, 1, 0, 0), nop, nop, 1'b0);
        expect_out(1, "jr_lw", ev(1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        expect_out(2, "jr_lw", ev(1, 0, 0, 0, 0, 2'b00, 2'b00, 0));

        // T5 mul completing after 16 RUN cycles
        pulse_reset();
        step(nop, mul, nop, nop, 1'b0);
        expect_out(1, "t5_issue", zero);
        for (int k = 0; k <= 16; k++) begin
            step(nop, mul, nop, nop, (k == 16));
            expect_out(1, "t5_run", ev(0, 1, (k == 0), 1, 0, 2'b00, 2'b00, 0));
        end
        step(nop, mul, nop, nop, 1'b0);
        expect_out(1, "t5_done", zero);
        step(nop, nop, nop, nop, 1'b1);
        expect_out(1, "t5_idle", zero);
        step(nop, nop, nop, nop, 1'b0);
        expect_out(1, "t5_ready_ignored", zero);

        // T6 div timeout on the 8-cycle unit, with stall_fd masking
        pulse_reset();
        step(ins(0, 5, 4, 0, 0), div_i, nop, nop, 1'b0);
        expect_out(2, "t6_issue", ev(1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        for (int k = 0; k <= 7; k++) begin
            step(ins(0, 5, 4, 0, 0), div_i, nop, nop, 1'b0);
            expect_out(2, "t6_run_masked", ev(0, 1, (k == 0), 1, 0, 2'b00, 2'b00, 0));
        end
        step(ins(0, 5, 4, 0, 0), div_i, nop, nop, 1'b0);
        expect_out(2, "t6_timeout", ev(1, 0, 0, 0, 1, 2'b00, 2'b00, 0));
        step(ins(0, 5, 4, 0, 0), div_i, nop, nop, 1'b0);
        expect_out(2, "t6_restart_sticky", ev(0, 1, 1, 1, 1, 2'b00, 2'b00, 0));

        // reset during RUN cycle 3
        pulse_reset();
        step(nop, div_i, nop, nop, 1'b0);
        expect_out(2, "rst_issue", zero);
        for (int k = 0; k <= 3; k++) begin
            step(nop, div_i, nop, nop, 1'b0);
            if (k == 3) reset = 1'b1;
            expect_out(2, "rst_run", ev(0, 1, (k == 0), 1, 0, 2'b00, 2'b00, 0));
        end
        step(nop, nop, nop, nop, 1'b0);
        reset = 1'b0;
        expect_out(1, "rst_mid_run", zero);
        expect_out(2, "rst_mid_run", zero);
        step(nop, nop, nop, nop, 1'b0);
        expect_out(1, "rst_no_start", zero);
        expect_out(2, "rst_no_start", zero);

        repeat (3) @(posedge clock);
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked entries, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
